// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready handshake on both sides.
// Define ALU_MUL_EN to enable the multi-cycle shift-add MUL on opcode 111; otherwise 111 is a single-cycle XNOR.
module alu_seq_nbit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Co,
    output logic             zero,
    output logic             ovf
);

    logic [2:0]       op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] res_f_s;
    logic             res_co_s;
    logic             res_ovf_s;
    logic             accept_s;
    logic             is_mul_op_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_f_s;
    logic             mul_co_s;

    logic [WIDTH-1:0] f_r;
    logic             co_r;
    logic             zero_r;
    logic             ovf_r;
    logic             out_valid_r;

    assign op_s      = {S2, S1, S0};
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign F         = f_r;
    assign Co        = co_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;

    // Single-cycle datapath; carries come from WIDTH+1 bit sums, SLT is sign(a-b) corrected by overflow
    always_comb begin
        sum_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Ci};
        diff_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
        res_f_s   = {WIDTH{1'b0}};
        res_co_s  = 1'b0;
        res_ovf_s = 1'b0;
        case (op_s)
            3'b000: begin
                res_f_s   = sum_s[WIDTH-1:0];
                res_co_s  = sum_s[WIDTH];
                res_ovf_s = add_ovf_s;
            end
            3'b001: begin
                res_f_s   = diff_s[WIDTH-1:0];
                res_co_s  = diff_s[WIDTH];
                res_ovf_s = sub_ovf_s;
            end
            3'b010:  res_f_s = a & b;
            3'b011:  res_f_s = a | b;
            3'b100:  res_f_s = a ^ b;
            3'b101:  res_f_s = ~(a | b);
            3'b110:  res_f_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
`ifdef ALU_MUL_EN
            3'b111:  res_f_s = {WIDTH{1'b0}};
`else
            3'b111:  res_f_s = ~(a ^ b);
`endif
            default: res_f_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nx_s;
    logic [WIDTH-1:0]   mplier_r;

    assign is_mul_op_s = (op_s == 3'b111);
    assign in_ready    = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign mul_f_s     = acc_nx_s[WIDTH-1:0];
    assign mul_co_s    = |acc_nx_s[2*WIDTH-1:WIDTH];

    // Next state and the partial-product step for the current multiplier bit
    always_comb begin
        state_nx_s = state_r;
        mul_done_s = 1'b0;
        if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
        end else begin
            acc_nx_s = acc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_op_s) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    mul_done_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Multiplier operands, accumulator and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (accept_s && is_mul_op_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (state_r == ST_MUL) begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            acc_r    <= acc_nx_s;
        end else begin
            cnt_r    <= cnt_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end
`else
    assign is_mul_op_s = 1'b0;
    assign mul_done_s  = 1'b0;
    assign mul_f_s     = {WIDTH{1'b0}};
    assign mul_co_s    = 1'b0;
    assign in_ready    = !rst && (!out_valid_r || out_ready);
`endif

    // Output register: single-cycle results, MUL completion, and consume
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            f_r         <= {WIDTH{1'b0}};
            co_r        <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept_s && !is_mul_op_s) begin
            out_valid_r <= 1'b1;
            f_r         <= res_f_s;
            co_r        <= res_co_s;
            zero_r      <= (res_f_s == {WIDTH{1'b0}});
            ovf_r       <= res_ovf_s;
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
        end else if (mul_done_s) begin
            out_valid_r <= 1'b1;
            f_r         <= mul_f_s;
            co_r        <= mul_co_s;
            zero_r      <= (mul_f_s == {WIDTH{1'b0}});
            ovf_r       <= 1'b0;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule
